// File: rtl/lane_align_pkg.sv
// -----------------------------------------------------------------------------
// lane_align_pkg
//   Shared types and constants for the lane alignment scheduler.
//   EYE_W       width of one lane's eye_width field
//   LANE_IDX_W  width of a lane index (covers up to 16 lanes)
//   EYE_NONE    eye_min value reported when no lane has been accepted
//   state_t     scheduler FSM state encoding
//   timer_width sizes the shared timer so it covers both the timeout and
//               the settle interval
// -----------------------------------------------------------------------------
package lane_align_pkg;

    localparam int EYE_W      = 6;
    localparam int LANE_IDX_W = 4;
    localparam logic [EYE_W-1:0] EYE_NONE = 6'h3f;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SELECT    = 4'd1,
        ST_ARM       = 4'd2,
        ST_WAIT_LOW  = 4'd3,
        ST_WAIT_HIGH = 4'd4,
        ST_SETTLE    = 4'd5,
        ST_CAPTURE   = 4'd6,
        ST_RELEASE   = 4'd7,
        ST_FINISH    = 4'd8
    } state_t;

    // At least 2 bits so the short WAIT_LOW limit (3) always fits.
    function automatic int timer_width(input int timeout_w, input int settle_cyc);
        int sw;
        int w;
        sw = $clog2(settle_cyc + 1);
        w  = (timeout_w > sw) ? timeout_w : sw;
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/lane_align_timer.sv
// -----------------------------------------------------------------------------
// lane_align_timer
//   Up-counter with synchronous clear (load), count enable and a
//   terminal-count flag. Saturates at all-ones so a long wait can never wrap
//   back past the terminal value.
// Ports
//   clk160  in   system clock
//   rst     in   synchronous reset, active-high
//   load    in   clear the count to zero (wins over en)
//   en      in   increment the count
//   limit   in   terminal value compared against the current count
//   tc      out  count equals limit
// -----------------------------------------------------------------------------
module lane_align_timer #(
    parameter int W = 20
) (
    input  logic         clk160,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk160) begin
        if (rst || load) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/lane_align_scheduler.sv
// -----------------------------------------------------------------------------
// lane_align_scheduler
//   Walks the enabled lanes one at a time: raises that lane's delay_mode,
//   waits for the auto sweep (delay_ready low then high), holds phase-2
//   tracking for SETTLE_CYC cycles, captures eye_width and records pass/fail,
//   timeouts and the narrowest accepted eye.
// Configuration macro
//   KEEP_TRACKING_EN  when defined, lanes that pass keep delay_mode high after
//                     their slot (continuous tracking); start, abort and rst
//                     clear them. Undefined: every lane is dropped after its slot.
// Ports
//   clk160        in   system clock
//   rst           in   synchronous reset, active-high
//   start         in   pulse, begin a scan over lane_mask (ignored while busy)
//   abort         in   level, drop delay_mode and return to idle (beats start)
//   lane_mask     in   lanes to align, sampled on start
//   delay_ready   in   per-lane ready from the delay controllers
//   eye_width     in   per-lane eye width, lane i at [6*i+:6]
//   delay_mode    out  per-lane auto-mode request
//   busy          out  scan in progress
//   done          out  one-cycle pulse at scan end
//   lane_ok       out  lane aligned with eye >= MIN_EYE and no timeout
//   lane_timeout  out  lane never reached delay_ready
//   cur_lane      out  lane being serviced
//   eye_min       out  smallest accepted eye (6'h3f if none)
//   eye_min_lane  out  lane of eye_min, lowest index on ties
// -----------------------------------------------------------------------------
module lane_align_scheduler
    import lane_align_pkg::*;
#(
    parameter int NLANES     = 8,
    parameter int TIMEOUT_W  = 20,
    parameter int SETTLE_CYC = 256,
    parameter int MIN_EYE    = 4
) (
    input  logic                    clk160,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NLANES-1:0]       lane_mask,
    input  logic [NLANES-1:0]       delay_ready,
    input  logic [EYE_W*NLANES-1:0] eye_width,
    output logic [NLANES-1:0]       delay_mode,
    output logic                    busy,
    output logic                    done,
    output logic [NLANES-1:0]       lane_ok,
    output logic [NLANES-1:0]       lane_timeout,
    output logic [LANE_IDX_W-1:0]   cur_lane,
    output logic [EYE_W-1:0]        eye_min,
    output logic [LANE_IDX_W-1:0]   eye_min_lane
);

    localparam int TMR_W = timer_width(TIMEOUT_W, SETTLE_CYC);
    localparam logic [TMR_W-1:0] TO_MAX     = TMR_W'((64'd1 << TIMEOUT_W) - 64'd1);
    localparam logic [TMR_W-1:0] SETTLE_LIM = TMR_W'(SETTLE_CYC - 1);
    // WAIT_LOW gives the controller four cycles to drop ready.
    localparam logic [TMR_W-1:0] LOW_LIM    = TMR_W'(3);
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(NLANES - 1);

    state_t                  state_q, state_d;
    logic [NLANES-1:0]       mode_q, mode_d;
    logic [NLANES-1:0]       mask_q, mask_d;
    logic [NLANES-1:0]       ok_q, ok_d;
    logic [NLANES-1:0]       to_q, to_d;
    logic [LANE_IDX_W-1:0]   cur_q, cur_d;
    logic [EYE_W-1:0]        emin_q, emin_d;
    logic [LANE_IDX_W-1:0]   elane_q, elane_d;

    logic                    tmr_load, tmr_en, tmr_tc;
    logic [TMR_W-1:0]        tmr_limit;

    logic [NLANES-1:0]       lane_sel;
    logic                    rdy_cur;
    logic                    mask_hit;
    logic [EYE_W-1:0]        eye_cur;

    // One-hot of the current lane; shifting avoids a width-mismatched index.
    assign lane_sel = NLANES'(1) << cur_q;
    assign rdy_cur  = |(delay_ready & lane_sel);
    assign mask_hit = |(mask_q & lane_sel);
    assign eye_cur  = EYE_W'(eye_width >> (EYE_W * cur_q));

    lane_align_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk160 (clk160),
        .rst    (rst),
        .load   (tmr_load),
        .en     (tmr_en),
        .limit  (tmr_limit),
        .tc     (tmr_tc)
    );

    always_ff @(posedge clk160) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            mask_q  <= '0;
            ok_q    <= '0;
            to_q    <= '0;
            cur_q   <= '0;
            emin_q  <= EYE_NONE;
            elane_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            ok_q    <= ok_d;
            to_q    <= to_d;
            cur_q   <= cur_d;
            emin_q  <= emin_d;
            elane_q <= elane_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        mask_d    = mask_q;
        ok_d      = ok_q;
        to_d      = to_q;
        cur_d     = cur_q;
        emin_d    = emin_q;
        elane_d   = elane_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_limit = SETTLE_LIM;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    mask_d  = lane_mask;
                    ok_d    = '0;
                    to_d    = '0;
                    emin_d  = EYE_NONE;
                    elane_d = '0;
                    cur_d   = '0;
`ifdef KEEP_TRACKING_EN
                    mode_d  = '0;
`endif
                    state_d = ST_SELECT;
                end
            end
            // Cleared mask bits are all below cur_lane, so an all-zero mask
            // means nothing is left to service.
            ST_SELECT: begin
                if (mask_q == '0) begin
                    state_d = ST_FINISH;
                end else if (mask_hit) begin
                    state_d = ST_ARM;
                end else begin
                    cur_d = cur_q + 1'b1;
                end
            end
            ST_ARM: begin
                mode_d   = mode_q | lane_sel;
                tmr_load = 1'b1;
                state_d  = ST_WAIT_LOW;
            end
            // The timer keeps running from ARM, so the timeout covers the
            // whole wait for the sweep, not just the high phase.
            ST_WAIT_LOW: begin
                tmr_en    = 1'b1;
                tmr_limit = LOW_LIM;
                if (!rdy_cur || tmr_tc) begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                tmr_en    = 1'b1;
                tmr_limit = TO_MAX;
                if (rdy_cur) begin
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end else if (tmr_tc) begin
                    to_d    = to_q | lane_sel;
                    state_d = ST_RELEASE;
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = ST_CAPTURE;
                end
            end
            // Strict less-than keeps the lowest index on equal eyes.
            ST_CAPTURE: begin
                if (eye_cur >= EYE_W'(MIN_EYE)) begin
                    ok_d = ok_q | lane_sel;
                    if (eye_cur < emin_q) begin
                        emin_d  = eye_cur;
                        elane_d = cur_q;
                    end
                end
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
`ifdef KEEP_TRACKING_EN
                if ((ok_q & lane_sel) == '0) begin
                    mode_d = mode_q & ~lane_sel;
                end
`else
                mode_d = mode_q & ~lane_sel;
`endif
                mask_d = mask_q & ~lane_sel;
                if (cur_q == LAST_LANE) begin
                    state_d = ST_FINISH;
                end else begin
                    cur_d   = cur_q + 1'b1;
                    state_d = ST_SELECT;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort drops every request; results keep whatever was gathered.
        if (abort) begin
            mode_d  = '0;
            state_d = ST_IDLE;
        end
    end

    assign delay_mode   = mode_q;
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done         = (state_q == ST_FINISH);
    assign lane_ok      = ok_q;
    assign lane_timeout = to_q;
    assign cur_lane     = cur_q;
    assign eye_min      = emin_q;
    assign eye_min_lane = elane_q;

endmodule
